// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: FSM state
// encoding, the routed master payload and the default address-map constants.
package wb_intercon_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Payload of the granted master as forwarded to the slave side
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
  } wb_req_t;

  // Default memory map: BRAM is an 8 KiB window, the rest decode the top nibble
  localparam logic [31:0] NIBBLE_MASK = 32'hf000_0000;
  localparam logic [31:0] BRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK   = 32'hffff_e000;
  localparam logic [31:0] VRAM_BASE   = 32'h2000_0000;
  localparam logic [31:0] MEM_BASE    = 32'h4000_0000;
  localparam logic [31:0] USB_BASE    = 32'hc000_0000;
  localparam logic [31:0] DEBUG_BASE  = 32'he000_0000;
  localparam logic [31:0] UART_BASE   = 32'hf000_0000;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker.
// Ports: req (one bit per master), last_grant (index granted previously),
//        grant_c (first requester after last_grant, wrapping), valid_c (any req).
module wb_rr_arbiter #(
  parameter int unsigned NM    = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NM-1:0]    req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_c,
  output logic             valid_c
);

  // Scan candidates last_grant+1, last_grant+2, ... last_grant+NM (mod NM)
  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    for (int unsigned off = 1; off <= NM; off++) begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (!valid_c && req[i] && (((32'(last_grant) + off) % NM) == i)) begin
          valid_c = 1'b1;
          grant_c = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/wb_intercon.sv
// Wishbone classic shared-bus interconnect: NM masters, NS slaves, one granted
// master at a time, round-robin arbitration, address decode with lowest-index
// priority, decode-miss and no-ack timeout errors.
// Ports: wb_clk_i/wb_rstn_i clock and async active-low reset;
//        m_* per-master request inputs, shared read data, per-master ack/err;
//        s_* shared slave request (offset address), per-slave cyc/stb, slave
//        read data and ack inputs.
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter int unsigned      NM      = 2,
  parameter int unsigned      NS      = 8,
  parameter logic [NS*32-1:0] S_BASE  = '0,
  parameter logic [NS*32-1:0] S_MASK  = {NS{NIBBLE_MASK}},
  parameter int unsigned      TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_cyc_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic [NS-1:0]    s_stb_o,
  output logic [NS-1:0]    s_cyc_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i
);

  localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e         state_q, state_d;
  logic [MW-1:0]  grant_q, grant_d;
  logic [MW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]  arb_idx;
  logic           arb_vld;
  wb_req_t        req;
  logic           g_cyc, g_stb;
  logic [NS-1:0]  sel_oh;
  logic           sel_vld;
  logic           ack_c;
  logic           to_hit;
  logic           busy;

  wb_rr_arbiter #(
    .NM    (NM),
    .IDX_W (MW)
  ) u_arb (
    .req        (m_cyc_i),
    .last_grant (last_q),
    .grant_c    (arb_idx),
    .valid_c    (arb_vld)
  );

  // Granted master request mux
  always_comb begin
    req   = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (MW'(i) == grant_q) begin
        req.adr = m_adr_i[i*32 +: 32];
        req.dat = m_dat_i[i*32 +: 32];
        req.sel = m_sel_i[i*4 +: 4];
        req.we  = m_we_i[i];
        g_cyc   = m_cyc_i[i];
        g_stb   = m_stb_i[i];
      end
    end
  end

  // Address decode; lowest matching slave wins so the select stays one-hot
  always_comb begin
    sel_oh  = '0;
    sel_vld = 1'b0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!sel_vld && ((req.adr & S_MASK[k*32 +: 32]) == S_BASE[k*32 +: 32])) begin
        sel_vld   = 1'b1;
        sel_oh[k] = 1'b1;
      end
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  // Slave-side routing and response return; everything is quiet outside BUSY
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    m_dat_o = '0;
    ack_c   = 1'b0;
    if (busy) begin
      s_dat_o = req.dat;
      s_sel_o = req.sel;
      s_we_o  = req.we;
      for (int unsigned k = 0; k < NS; k++) begin
        if (sel_oh[k]) begin
          s_cyc_o[k] = g_cyc;
          s_stb_o[k] = g_stb;
          s_adr_o    = req.adr & ~S_MASK[k*32 +: 32];
          m_dat_o    = s_dat_i[k*32 +: 32];
          ack_c      = s_ack_i[k];
        end
      end
    end
  end

  // Only the granted master ever sees ack or err
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (MW'(i) == grant_q) begin
        m_ack_o[i] = busy && ack_c;
        m_err_o[i] = (state_q == ST_ERR);
      end
    end
  end

  // Next-state logic; the counter clears unless a strobe waits in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
        end else if (g_stb && !sel_vld) begin
          state_d = ST_ERR;
        end else if (g_stb && !ack_c && to_hit) begin
          state_d = ST_ERR;
        end else if (g_stb && !ack_c && (TIMEOUT != 0)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_BUSY;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= MW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: two masters, eight slaves on the default map
// plus an overlapping slave 1, simple latency-programmable slave responders.
module tb_wb_intercon;
  import wb_intercon_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 8;
  localparam logic [NS*32-1:0] BASES = {32'h6000_0000, UART_BASE, DEBUG_BASE, USB_BASE,
                                        VRAM_BASE, MEM_BASE, 32'h0000_0000, BRAM_BASE};
  localparam logic [NS*32-1:0] MASKS = {{7{NIBBLE_MASK}}, BRAM_MASK};

  logic             clk;
  logic             rst_n;
  logic [NM*32-1:0] m_adr;
  logic [NM*32-1:0] m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we;
  logic [NM-1:0]    m_stb;
  logic [NM-1:0]    m_cyc;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS*32-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sdat [NS];
  int          lat  [NS];
  logic        dead [NS];
  int          scnt [NS];

  wb_intercon #(
    .NM      (NM),
    .NS      (NS),
    .S_BASE  (BASES),
    .S_MASK  (MASKS),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_we_i    (m_we),
    .m_stb_i   (m_stb),
    .m_cyc_i   (m_cyc),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_stb_o   (s_stb_o),
    .s_cyc_o   (s_cyc_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave responders: ack once stb has been held for lat cycles
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++)
      scnt[k] <= (s_stb_o[k] && !s_ack_i[k]) ? scnt[k] + 1 : 0;
  end

  always_comb begin
    s_ack_i = '0;
    s_dat_i = '0;
    for (int k = 0; k < NS; k++) begin
      s_ack_i[k]         = s_stb_o[k] && !dead[k] && (scnt[k] >= lat[k]);
      s_dat_i[k*32 +: 32] = sdat[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input logic cyc, input logic stb);
    m_adr[m*32 +: 32] = adr;
    m_dat[m*32 +: 32] = dat;
    m_sel[m*4 +: 4]   = sel;
    m_we[m]           = we;
    m_cyc[m]          = cyc;
    m_stb[m]          = stb;
  endtask

  // Wait (bounded) for any ack or err; n = negedges seen before the event
  task automatic wait_evt(input int budget, output int n, output logic [NS-1:0] stb_seen);
    logic got;
    got      = 1'b0;
    n        = 0;
    stb_seen = '0;
    while (!got && n < budget) begin
      @(negedge clk);
      stb_seen |= s_stb_o;
      if ((|m_ack_o) || (|m_err_o)) got = 1'b1;
      else n++;
    end
    chk("evt_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NS-1:0] seen;
    logic [NM-1:0] a;
    int seq [4];
    int nack;
    int budget;

    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_stb = '0; m_cyc = '0;
    for (int k = 0; k < NS; k++) begin
      sdat[k] = 32'h5100_0000 + 32'(k);
      lat[k]  = 0;
      dead[k] = 1'b0;
    end
    sdat[2] = 32'hDEAD_BEEF;

    // Reset state
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("rst_m_err", 32'(m_err_o), 32'h0);
    chk("rst_m_dat", m_dat_o, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Read from slave 2 with 3 wait cycles
    lat[2] = 3;
    drive(0, 32'h4000_0010, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    wait_evt(20, n, seen);
    chk("rd_latency", 32'(n), 32'd4);
    chk("rd_s_adr", s_adr_o, 32'h0000_0010);
    chk("rd_s_stb", 32'(s_stb_o), 32'h04);
    chk("rd_ack", 32'(m_ack_o), 32'h1);
    chk("rd_err", 32'(m_err_o), 32'h0);
    chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rd_ack_pulse", 32'(m_ack_o), 32'h0);
    repeat (2) @(posedge clk); #1;

    // Overlapping map: 0x100 belongs to slave 0 only; write from master 1
    drive(1, 32'h0000_0100, 32'h1234_5678, 4'h3, 1'b1, 1'b1, 1'b1);
    wait_evt(20, n, seen);
    chk("ovl_latency", 32'(n), 32'd1);
    chk("ovl_s_stb", 32'(s_stb_o), 32'h01);
    chk("ovl_s_cyc", 32'(s_cyc_o), 32'h01);
    chk("ovl_s_adr", s_adr_o, 32'h0000_0100);
    chk("ovl_s_dat", s_dat_o, 32'h1234_5678);
    chk("ovl_s_sel", 32'(s_sel_o), 32'h3);
    chk("ovl_s_we", 32'(s_we_o), 32'h1);
    chk("ovl_ack", 32'(m_ack_o), 32'h2);
    chk("ovl_dat", m_dat_o, 32'h5100_0000);
    @(posedge clk); #1;
    drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Round robin with 1-cycle transfers; last grant was master 1
    lat[2] = 0;
    drive(0, 32'h4000_0000, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    drive(1, 32'h4000_0010, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    nack   = 0;
    budget = 0;
    while (nack < 4 && budget < 60) begin
      @(negedge clk);
      budget++;
      a = m_ack_o;
      if (|a) begin
        chk("rr_onehot", 32'($countones(a)), 32'd1);
        seq[nack] = a[1] ? 1 : 0;
        nack++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < int'(NM); i++) begin
        m_cyc[i] = !a[i];
        m_stb[i] = !a[i];
      end
    end
    chk("rr_count", 32'(nack), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_grant", 32'(seq[i]), 32'(i % 2));
    m_cyc = '0;
    m_stb = '0;
    repeat (3) @(posedge clk); #1;

    // Unmapped address: single err pulse, no slave strobed
    drive(0, 32'h9000_0000, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    wait_evt(20, n, seen);
    chk("unm_latency", 32'(n), 32'd2);
    chk("unm_err", 32'(m_err_o), 32'h1);
    chk("unm_ack", 32'(m_ack_o), 32'h0);
    chk("unm_no_stb", 32'(seen | s_stb_o), 32'h0);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("unm_err_pulse", 32'(m_err_o), 32'h0);
    repeat (2) @(posedge clk); #1;

    // Timeout: master holds cyc, then raises stb toward a dead slave 3
    dead[3] = 1'b1;
    drive(0, 32'h2000_0000, 32'h0, 4'hf, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("to_s_cyc_held", 32'(s_cyc_o), 32'h08);
    @(posedge clk); #1;
    m_stb[0] = 1'b1;
    wait_evt(30, n, seen);
    chk("to_latency", 32'(n), 32'd9);
    chk("to_err", 32'(m_err_o), 32'h1);
    chk("to_s_cyc_low", 32'(s_cyc_o), 32'h0);
    chk("to_s_stb_low", 32'(s_stb_o), 32'h0);
    @(posedge clk); #1;
    dead[3] = 1'b0;
    wait_evt(10, n, seen);
    chk("to_recover_lat", 32'(n), 32'd0);
    chk("to_recover_ack", 32'(m_ack_o), 32'h1);
    chk("to_recover_dat", m_dat_o, 32'h5100_0003);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Reset during a BUSY transfer (last grant is master 0 at this point)
    dead[3] = 1'b1;
    drive(0, 32'h2000_0000, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("mr_busy_stb", 32'(s_stb_o), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_s_stb", 32'(s_stb_o), 32'h0);
    chk("mr_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("mr_s_adr", s_adr_o, 32'h0);
    chk("mr_m_ack", 32'(m_ack_o), 32'h0);
    chk("mr_m_err", 32'(m_err_o), 32'h0);
    dead[3] = 1'b0;
    drive(0, 32'h4000_0000, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    drive(1, 32'h4000_0010, 32'h0, 4'hf, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mr_hold_ack", 32'(m_ack_o), 32'h0);
    chk("mr_hold_err", 32'(m_err_o), 32'h0);
    chk("mr_hold_stb", 32'(s_stb_o), 32'h0);
    #1 rst_n = 1'b1;
    wait_evt(10, n, seen);
    chk("mr_first_lat", 32'(n), 32'd0);
    chk("mr_first_grant", 32'(m_ack_o), 32'h1);
    @(posedge clk); #1;
    m_cyc = '0;
    m_stb = '0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
